// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: memory-side model for the data cache's line refill /
// writeback port and its uncached single-word port. One transaction is in
// flight at a time; its response pulse fires a fixed number of cycles after
// acceptance. Array writes take effect at the acceptance edge, so any later
// read observes them.
//
// Optional feature, macro DMEM_ADDR_PATTERN_EN: a per-line written bit
// (cleared by reset) makes unwritten lines read back as an address pattern,
// each word = {line address[31:5], word index, 2'b00}. Partial writes to an
// unwritten line merge into that pattern. Without the macro the array has no
// reset; it relies on a zero power-up value (FPGA bitstream default).

module dcache_mem_responder #(
    parameter int LINE_DEPTH = 64,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [255:0] ret_data,
    input  logic         wr_req,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [255:0] wr_data,
    output logic         wr_rdy,
    output logic         data_bvalid_o,
    input  logic         ducache_ren_i,
    input  logic [31:0]  ducache_araddr_i,
    output logic         ducache_rvalid_o,
    output logic [31:0]  ducache_rdata_o,
    input  logic         ducache_wen_i,
    input  logic [31:0]  ducache_wdata_i,
    input  logic [31:0]  ducache_awaddr_i,
    input  logic [3:0]   ducache_strb,
    output logic         ducache_bvalid_o
);

    localparam int IDX_W   = $clog2(LINE_DEPTH);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_WAIT,
        S_UR_WAIT,
        S_UW_WAIT
    } state_t;

    logic [255:0]     r_mem [LINE_DEPTH];
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic             r_rdy;
    logic             r_ret_valid;
    logic [255:0]     r_ret_data;
    logic             r_bvalid;
    logic             r_urvalid;
    logic [31:0]      r_urdata;
    logic             r_ubvalid;

    logic             w_idle;
    logic             w_sel_wr;
    logic             w_sel_rd;
    logic             w_sel_uw;
    logic             w_sel_ur;
    logic             w_do_write;
    logic             w_full;
    logic [31:0]      w_wa;
    logic [31:0]      w_wd;
    logic [3:0]       w_ws;
    logic [2:0]       w_wword;
    logic [IDX_W-1:0] w_widx;
    logic [IDX_W-1:0] w_ridx;
    logic [255:0]     w_old_line;
    logic [255:0]     w_new_line;
    logic [255:0]     w_rd_line;
    logic             w_unused;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

`ifdef DMEM_ADDR_PATTERN_EN
    logic [LINE_DEPTH-1:0] r_written;

    function automatic logic [255:0] line_pattern(input logic [31:0] addr);
        logic [255:0] p;
        for (int i = 0; i < 8; i++) begin
            p[32*i +: 32] = {addr[31:5], 3'(i), 2'b00};
        end
        return p;
    endfunction
`endif

    // Fixed priority: writeback ahead of refill, then uncached write, then uncached read.
    assign w_idle   = (r_state == S_IDLE);
    assign w_sel_wr = wr_req;
    assign w_sel_rd = !wr_req && rd_req;
    assign w_sel_uw = !wr_req && !rd_req && ducache_wen_i;
    assign w_sel_ur = !wr_req && !rd_req && !ducache_wen_i && ducache_ren_i;

    assign w_wa    = w_sel_wr ? wr_addr : ducache_awaddr_i;
    assign w_wd    = w_sel_wr ? wr_data[31:0] : ducache_wdata_i;
    assign w_ws    = w_sel_wr ? wr_wstrb : ducache_strb;
    assign w_full  = w_sel_wr && (wr_wstrb == 4'hF);
    assign w_wword = w_wa[4:2];
    assign w_widx  = w_wa[5 +: IDX_W];
    assign w_ridx  = r_addr[5 +: IDX_W];

    // A zero strobe still gets a response but leaves the line (and its written bit) alone.
    assign w_do_write = w_idle && (w_sel_wr || w_sel_uw) && (w_ws != 4'b0000);

`ifdef DMEM_ADDR_PATTERN_EN
    assign w_old_line = r_written[w_widx] ? r_mem[w_widx] : line_pattern(w_wa);
    assign w_rd_line  = r_written[w_ridx] ? r_mem[w_ridx] : line_pattern(r_addr);
`else
    assign w_old_line = r_mem[w_widx];
    assign w_rd_line  = r_mem[w_ridx];
`endif

    assign w_unused = ^{rd_type, rd_addr, wr_addr, ducache_araddr_i, ducache_awaddr_i, r_addr};

    // Build the post-write line: whole line on a full strobe, otherwise one byte-merged word.
    always_comb begin
        w_new_line = w_old_line;
        if (w_full) begin
            w_new_line = wr_data;
        end else begin
            w_new_line[{w_wword, 5'b00000} +: 32] =
                merge_bytes(w_old_line[{w_wword, 5'b00000} +: 32], w_wd, w_ws);
        end
    end

    // Array update at the acceptance edge of a line or uncached write.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[w_widx] <= w_new_line;
        end
    end

`ifdef DMEM_ADDR_PATTERN_EN
    // Track which lines have been written since reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_written <= '0;
        end else if (w_do_write) begin
            r_written[w_widx] <= 1'b1;
        end
    end
`endif

    // Transaction FSM: accept in IDLE, count down the latency, pulse the matching response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_rdy       <= 1'b1;
            r_ret_valid <= 1'b0;
            r_ret_data  <= '0;
            r_bvalid    <= 1'b0;
            r_urvalid   <= 1'b0;
            r_urdata    <= '0;
            r_ubvalid   <= 1'b0;
        end else begin
            r_ret_valid <= 1'b0;
            r_ret_data  <= '0;
            r_bvalid    <= 1'b0;
            r_urvalid   <= 1'b0;
            r_urdata    <= '0;
            r_ubvalid   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_wr) begin
                        r_state <= S_WR_WAIT;
                        r_cnt   <= WR_LOAD;
                        r_rdy   <= 1'b0;
                    end else if (w_sel_rd) begin
                        r_state <= S_RD_WAIT;
                        r_cnt   <= RD_LOAD;
                        r_addr  <= rd_addr;
                        r_rdy   <= 1'b0;
                    end else if (w_sel_uw) begin
                        r_state <= S_UW_WAIT;
                        r_cnt   <= WR_LOAD;
                        r_rdy   <= 1'b0;
                    end else if (w_sel_ur) begin
                        r_state <= S_UR_WAIT;
                        r_cnt   <= RD_LOAD;
                        r_addr  <= ducache_araddr_i;
                        r_rdy   <= 1'b0;
                    end
                end
                default: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_rdy   <= 1'b1;
                        case (r_state)
                            S_RD_WAIT: begin
                                r_ret_valid <= 1'b1;
                                r_ret_data  <= w_rd_line;
                            end
                            S_UR_WAIT: begin
                                r_urvalid <= 1'b1;
                                r_urdata  <= w_rd_line[{r_addr[4:2], 5'b00000} +: 32];
                            end
                            S_WR_WAIT: r_bvalid  <= 1'b1;
                            default:   r_ubvalid <= 1'b1;
                        endcase
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign rd_rdy           = r_rdy;
    assign wr_rdy           = r_rdy;
    assign ret_valid        = r_ret_valid;
    assign ret_data         = r_ret_data;
    assign data_bvalid_o    = r_bvalid;
    assign ducache_rvalid_o = r_urvalid;
    assign ducache_rdata_o  = r_urdata;
    assign ducache_bvalid_o = r_ubvalid;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder with default parameters
// (64 lines, read latency 4, write latency 2). Expected values depend on
// whether DMEM_ADDR_PATTERN_EN is defined.

module tb_dcache_mem_responder;

    localparam int K_RD = 0;
    localparam int K_WB = 1;
    localparam int K_UR = 2;
    localparam int K_UW = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [255:0] ret_data;
    logic         wr_req;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [255:0] wr_data;
    logic         wr_rdy;
    logic         data_bvalid_o;
    logic         ducache_ren_i;
    logic [31:0]  ducache_araddr_i;
    logic         ducache_rvalid_o;
    logic [31:0]  ducache_rdata_o;
    logic         ducache_wen_i;
    logic [31:0]  ducache_wdata_i;
    logic [31:0]  ducache_awaddr_i;
    logic [3:0]   ducache_strb;
    logic         ducache_bvalid_o;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dcache_mem_responder dut (
        .clk              (clk),
        .reset            (reset),
        .rd_req           (rd_req),
        .rd_type          (rd_type),
        .rd_addr          (rd_addr),
        .rd_rdy           (rd_rdy),
        .ret_valid        (ret_valid),
        .ret_data         (ret_data),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_wstrb         (wr_wstrb),
        .wr_data          (wr_data),
        .wr_rdy           (wr_rdy),
        .data_bvalid_o    (data_bvalid_o),
        .ducache_ren_i    (ducache_ren_i),
        .ducache_araddr_i (ducache_araddr_i),
        .ducache_rvalid_o (ducache_rvalid_o),
        .ducache_rdata_o  (ducache_rdata_o),
        .ducache_wen_i    (ducache_wen_i),
        .ducache_wdata_i  (ducache_wdata_i),
        .ducache_awaddr_i (ducache_awaddr_i),
        .ducache_strb     (ducache_strb),
        .ducache_bvalid_o (ducache_bvalid_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    function automatic logic get_valid(input int kind);
        case (kind)
            K_RD:    return ret_valid;
            K_WB:    return data_bvalid_o;
            K_UR:    return ducache_rvalid_o;
            default: return ducache_bvalid_o;
        endcase
    endfunction

    function automatic logic [255:0] get_data(input int kind);
        if (kind == K_RD) return ret_data;
        return {224'b0, ducache_rdata_o};
    endfunction

    function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] step);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + step * 32'(i);
        return l;
    endfunction

    // Called right after the acceptance edge: response is due exactly lat edges later.
    task automatic expect_resp(input string tag, input int kind, input int lat,
                               input logic [255:0] exp);
        for (int k = 1; k < lat; k++) begin
            tick();
            chk1({tag, " early"}, get_valid(kind), 1'b0);
        end
        tick();
        chk1({tag, " pulse"}, get_valid(kind), 1'b1);
        if (kind == K_RD || kind == K_UR) chk({tag, " data"}, get_data(kind), exp);
        tick();
        chk1({tag, " drop"}, get_valid(kind), 1'b0);
        if (kind == K_RD || kind == K_UR) chk({tag, " data clr"}, get_data(kind), 256'b0);
    endtask

    initial begin
        logic [255:0] exp_line;
        logic [255:0] tmp;

        reset = 1'b0;
        rd_req = 1'b0; rd_type = 3'b0; rd_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        ducache_ren_i = 1'b0; ducache_araddr_i = '0;
        ducache_wen_i = 1'b0; ducache_wdata_i = '0; ducache_awaddr_i = '0; ducache_strb = '0;

        // Reset values
        tick(); tick();
        chk1("rst rd_rdy", rd_rdy, 1'b1);
        chk1("rst wr_rdy", wr_rdy, 1'b1);
        chk1("rst ret_valid", ret_valid, 1'b0);
        chk1("rst bvalid", data_bvalid_o, 1'b0);
        chk1("rst urvalid", ducache_rvalid_o, 1'b0);
        chk1("rst ubvalid", ducache_bvalid_o, 1'b0);
        chk("rst ret_data", ret_data, 256'b0);
        chk("rst urdata", {224'b0, ducache_rdata_o}, 256'b0);
        reset = 1'b1;
        tick();

        // Line refill of an untouched line
        rd_req = 1'b1; rd_addr = 32'h40; rd_type = 3'b100;
        tick();
        rd_req = 1'b0;
        chk1("refill rd_rdy busy", rd_rdy, 1'b0);
        chk1("refill wr_rdy busy", wr_rdy, 1'b0);
`ifdef DMEM_ADDR_PATTERN_EN
        exp_line = mk_line(32'h40, 32'd4);
`else
        exp_line = '0;
`endif
        expect_resp("refill", K_RD, 4, exp_line);
        chk1("refill rd_rdy idle", rd_rdy, 1'b1);

        // Writeback and refill together: write wins, read follows
        wr_req = 1'b1; wr_addr = 32'h20; wr_wstrb = 4'hF; wr_data = mk_line(32'hA0, 32'd1);
        rd_req = 1'b1; rd_addr = 32'h20;
        tick();
        wr_req = 1'b0;
        chk1("wb wr_rdy busy", wr_rdy, 1'b0);
        expect_resp("wb", K_WB, 2, 256'b0);
        rd_req = 1'b0;
        chk1("wb->rd accepted", rd_rdy, 1'b0);
        expect_resp("wb refill", K_RD, 4, mk_line(32'hA0, 32'd1));

        // Uncached byte write then uncached read
        ducache_wen_i = 1'b1; ducache_awaddr_i = 32'h14; ducache_strb = 4'b0010;
        ducache_wdata_i = 32'h0000_5500;
        tick();
        ducache_wen_i = 1'b0;
        expect_resp("uw", K_UW, 2, 256'b0);
        ducache_ren_i = 1'b1; ducache_araddr_i = 32'h14;
        tick();
        ducache_ren_i = 1'b0;
`ifdef DMEM_ADDR_PATTERN_EN
        expect_resp("ur", K_UR, 4, 256'h5514);
`else
        expect_resp("ur", K_UR, 4, 256'h5500);
`endif

        // Partial line write: byte 0 of word 2 in line 0
        tmp = {8{32'hCAFE_BABE}};
        tmp[31:0] = 32'h0000_00FF;
        wr_req = 1'b1; wr_addr = 32'h08; wr_wstrb = 4'b0001; wr_data = tmp;
        tick();
        wr_req = 1'b0;
        expect_resp("pw", K_WB, 2, 256'b0);
        rd_req = 1'b1; rd_addr = 32'h0;
        tick();
        rd_req = 1'b0;
`ifdef DMEM_ADDR_PATTERN_EN
        exp_line = mk_line(32'h0, 32'd4);
        exp_line[191:160] = 32'h0000_5514;
`else
        exp_line = '0;
        exp_line[191:160] = 32'h0000_5500;
`endif
        exp_line[95:64] = 32'h0000_00FF;
        expect_resp("pw rd", K_RD, 4, exp_line);

        // Zero strobe: response only, line untouched
        wr_req = 1'b1; wr_addr = 32'h20; wr_wstrb = 4'b0000; wr_data = {256{1'b1}};
        tick();
        wr_req = 1'b0;
        expect_resp("zs", K_WB, 2, 256'b0);
        rd_req = 1'b1; rd_addr = 32'h20;
        tick();
        rd_req = 1'b0;
        expect_resp("zs rd", K_RD, 4, mk_line(32'hA0, 32'd1));

        // Address wrap: 0x800 aliases line 0
        wr_req = 1'b1; wr_addr = 32'h800; wr_wstrb = 4'hF; wr_data = mk_line(32'hB0, 32'd1);
        tick();
        wr_req = 1'b0;
        expect_resp("wrap wr", K_WB, 2, 256'b0);
        rd_req = 1'b1; rd_addr = 32'h0;
        tick();
        rd_req = 1'b0;
        expect_resp("wrap rd", K_RD, 4, mk_line(32'hB0, 32'd1));

        // Uncached write beats uncached read in the same cycle
        ducache_wen_i = 1'b1; ducache_awaddr_i = 32'h14; ducache_strb = 4'hF;
        ducache_wdata_i = 32'h1234_5678;
        ducache_ren_i = 1'b1; ducache_araddr_i = 32'h14;
        tick();
        ducache_wen_i = 1'b0;
        expect_resp("uw2", K_UW, 2, 256'b0);
        ducache_ren_i = 1'b0;
        expect_resp("ur2", K_UR, 4, 256'h1234_5678);

        // Reset two cycles into a read: no response ever appears
        rd_req = 1'b1; rd_addr = 32'h20;
        tick();
        rd_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk1("midrst rd_rdy", rd_rdy, 1'b1);
        chk1("midrst ret_valid", ret_valid, 1'b0);
        tick(); tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk1("midrst no pulse", ret_valid, 1'b0);
        end
        rd_req = 1'b1; rd_addr = 32'h20;
        tick();
        rd_req = 1'b0;
`ifdef DMEM_ADDR_PATTERN_EN
        exp_line = mk_line(32'h20, 32'd4);
`else
        exp_line = mk_line(32'hA0, 32'd1);
`endif
        expect_resp("post rst rd", K_RD, 4, exp_line);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Synthesizable memory-side responder for the data cache's refill/writeback and uncached-access interfaces.
- Accepts line reads (rd_req), line writebacks (wr_req), and single-word uncached reads and writes (ducache_ren_i/ducache_wen_i).
- Serves them from an internal line-organised array with programmable latency.
- Used as the dcache's memory in unit simulation and as the backing store on FPGA bring-up before the AXI bridge exists.

Parameters:
- LINE_DEPTH, 64: number of 256-bit lines; power of two, at least 2.
- RD_LATENCY, 4: cycles from read acceptance to the response pulse; at least 1.
- WR_LATENCY, 2: cycles from write acceptance to the response pulse; at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- rd_req  in  1  line read request
- rd_type  in  3  read type; accepted, ignored (always a full line)
- rd_addr  in  32  read byte address; bits [4:0] ignored
- rd_rdy  out  1  can accept rd_req
- ret_valid  out  1  line read data valid, one-cycle pulse
- ret_data  out  256  line data; word i in bits [32i+31:32i]
- wr_req  in  1  line write request
- wr_addr  in  32  write byte address
- wr_wstrb  in  4  byte strobe
- wr_data  in  256  write data
- wr_rdy  out  1  can accept wr_req
- data_bvalid_o  out  1  line write response, one-cycle pulse
- ducache_ren_i  in  1  uncached read request
- ducache_araddr_i  in  32  uncached read address
- ducache_rvalid_o  out  1  uncached read valid, one-cycle pulse
- ducache_rdata_o  out  32  uncached read data
- ducache_wen_i  in  1  uncached write request
- ducache_wdata_i  in  32  uncached write data
- ducache_awaddr_i  in  32  uncached write address
- ducache_strb  in  4  uncached byte strobe
- ducache_bvalid_o  out  1  uncached write response, one-cycle pulse

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - reset is asynchronous, active-low.
- Reset values:
  - rd_rdy=1, wr_rdy=1.
  - All valid outputs are 0.
  - ret_data=0, ducache_rdata_o=0.
  - FSM in IDLE, latency counter 0.
- Reset mid-operation: any pending response is dropped; no response pulse is issued after reset deasserts.
- Addressing:
  - line index = addr[5 +: log2(LINE_DEPTH)]; word = addr[4:2].
  - Higher address bits are ignored, so addresses wrap modulo LINE_DEPTH*32 bytes.
- FSM states: IDLE, RD_WAIT, WR_WAIT, UR_WAIT, UW_WAIT.
  - rd_rdy and wr_rdy are 1 only in IDLE.
- Acceptance:
  - Requests are sampled only in IDLE; requesters hold a request until it is accepted.
  - Priority when several are asserted in the same cycle: wr_req > rd_req > ducache_wen_i > ducache_ren_i. Writeback always precedes refill.
  - Losers are not dropped; they are served on later IDLE cycles while they remain asserted.
- Latency counter:
  - On acceptance, load RD_LATENCY-1 (reads) or WR_LATENCY-1 (writes).
  - Decrement each cycle in a WAIT state.
  - At 0, pulse the matching valid output for exactly one cycle, then return to IDLE.
  - Response edge = acceptance edge + latency. The next request can be accepted the cycle after the pulse.
- Line read:
  - ret_data is captured from the array when the pulse is generated.
  - ret_data is valid only while ret_valid=1 and returns to 0 afterwards.
- Line write:
  - The array is updated at the acceptance edge.
  - wr_wstrb=4'b1111: the whole 256-bit line is written.
  - Any other strobe: only word wr_addr[4:2] is written, bytes enabled per wr_wstrb, data taken from wr_data[31:0].
  - wr_wstrb=0: no array change, but data_bvalid_o is still pulsed.
- Uncached read: ducache_rdata_o = array word at ducache_araddr_i, sampled when the pulse is generated; 0 otherwise.
- Uncached write:
  - The byte-enabled write (ducache_strb) happens at the acceptance edge.
  - ducache_bvalid_o pulses after WR_LATENCY.
- Read-after-write: a read accepted after a write's acceptance sees the new data.
- Ordering: one outstanding transaction at a time; responses come back in acceptance order.

Optional Feature:
- Macro: DMEM_ADDR_PATTERN_EN.
- When defined:
  - A per-line written bit is kept and cleared by reset.
  - Reads of an unwritten line return the address pattern: each word = {line-aligned address[31:5], word index, 2'b00}.
  - Any line or uncached write sets the bit. Words not covered by the write keep the pattern value, which is merged at write time.
- When not defined:
  - No tracking bits.
  - The array is zero at time 0 and is not affected by reset.

Test Plan:
- Line refill: reset low 2 cycles; rd_req=1, rd_addr=0x40 (pattern build) -> rd_rdy=0 next cycle; ret_valid one-cycle pulse 4 cycles after acceptance; ret_data word i = 0x40+4i.
- Writeback then refill: wr_req with wr_addr=0x20, wstrb=4'hF, data word i = 0xA0+i, plus rd_req=0x20 in the same cycle -> write accepted first; data_bvalid_o 2 cycles later; read then accepted; ret_data word 3 = 0xA3.
- Uncached byte write: ducache_wen_i, awaddr=0x14, strb=4'b0010, wdata=0x0000_5500; then ren at 0x14 -> ducache_bvalid_o after 2 cycles; ducache_rdata_o = 0x0000_5514 (pattern) or 0x0000_5500 (zero init).
- Partial line write: wr_wstrb=4'b0001, wr_addr=0x08, wr_data[31:0]=0xFF -> only byte 0 of word 2 changes; other 7 words unchanged on re-read.
- Wrap: LINE_DEPTH=64, write line at 0x800, read 0x0 -> same data returned.
- Reset mid-read: drop reset 2 cycles after rd_req acceptance -> ret_valid never pulses; rd_rdy=1 after reset; a new read completes normally.
